// File: rtl/xcorr_peak_finder_pkg.sv
// Shared constants, types and state encoding for the cross-correlation peak finder.
// The lag helper converts a vector index into a signed lag relative to the centre tap.
package xcorr_pkg;

    localparam int NUM_BITS_XCORR    = 31;
    localparam int MAX_SAMPLES_DELAY = 11;
    localparam int NUM_XCORRS        = 6;
    localparam int L                 = 2 * MAX_SAMPLES_DELAY + 1;
    localparam int LAG_BITS          = $clog2(MAX_SAMPLES_DELAY + 1) + 1;
    localparam int IDX_BITS          = $clog2(L);

    typedef logic signed [NUM_BITS_XCORR-1:0] xcorr_t;
    typedef xcorr_t [L-1:0]                   xcorr_vec_t;
    typedef logic signed [LAG_BITS-1:0]       lag_t;
    typedef logic [IDX_BITS-1:0]              idx_t;
    typedef xcorr_vec_t [NUM_XCORRS-1:0]      xcorr_set_t;
    typedef lag_t [NUM_XCORRS-1:0]            lag_set_t;
    typedef xcorr_t [NUM_XCORRS-1:0]          peak_set_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam xcorr_t XCORR_MIN = {1'b1, {(NUM_BITS_XCORR-1){1'b0}}};

    // Modular subtraction; the result always lies in -MAX_SAMPLES_DELAY..+MAX_SAMPLES_DELAY.
    function automatic lag_t idx_to_lag(input idx_t idx);
        return lag_t'(idx - idx_t'(MAX_SAMPLES_DELAY));
    endfunction

endpackage

// File: rtl/xcorr_peak_finder_if.sv
// Bus between the correlation stage / direction-of-arrival logic and the peak finder.
// The master side supplies correlation vectors; the slave side is the peak finder.
interface xcorr_peak_finder_if;
    import xcorr_pkg::*;

    logic       validIn;
    xcorr_set_t xCorrIn;
    logic       busy;
    logic       validOut;
    lag_set_t   lagOut;
    peak_set_t  peakOut;
    logic [7:0] dropCount;

    modport master (
        output validIn, xCorrIn,
        input  busy, validOut, lagOut, peakOut, dropCount
    );

    modport slave (
        input  validIn, xCorrIn,
        output busy, validOut, lagOut, peakOut, dropCount
    );

endinterface

// File: rtl/xcorr_peak_finder_argmax_lane.sv
// One running-maximum tracker for a single microphone pair.
// Strict comparison keeps the earliest index on ties.
module argmax_lane
    import xcorr_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  logic   en,
    input  xcorr_t sample,
    input  idx_t   idx,
    output xcorr_t best,
    output idx_t   best_idx
);

    xcorr_t best_r;
    idx_t   best_idx_r;

    // Best value and its index, preset at start and updated while enabled
    always_ff @(posedge clk) begin
        if (!rst) begin
            best_r     <= '0;
            best_idx_r <= '0;
        end else if (start) begin
            best_r     <= XCORR_MIN;
            best_idx_r <= '0;
        end else if (en && (sample > best_r)) begin
            best_r     <= sample;
            best_idx_r <= idx;
        end
    end

    assign best     = best_r;
    assign best_idx = best_idx_r;

endmodule

// File: rtl/xcorr_peak_finder.sv
// Snapshots the correlation vectors, scans all lags one per cycle and reports the
// per-pair argmax lag and peak value; requests arriving mid-scan are counted and dropped.
module xcorr_peak_finder
    import xcorr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    xcorr_peak_finder_if.slave   bus
);

    state_t     state_r;
    state_t     next_state_s;
    logic       capture_s;
    logic       scan_s;
    logic       done_s;
    xcorr_set_t snap_r;
    idx_t       idx_r;
    logic       busy_r;
    logic       valid_out_r;
    lag_set_t   lag_r;
    peak_set_t  peak_r;
    logic [7:0] drop_r;
    xcorr_t     best_s     [NUM_XCORRS];
    idx_t       best_idx_s [NUM_XCORRS];

    // Next-state and control strobes
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        scan_s       = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.validIn) begin
                    next_state_s = ST_SCAN;
                    capture_s    = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                scan_s = 1'b1;
                if (idx_r == idx_t'(L - 1)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                done_s       = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Snapshot of the input vectors and the lag scan index
    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_r <= '0;
            idx_r  <= '0;
        end else if (capture_s) begin
            snap_r <= bus.xCorrIn;
            idx_r  <= '0;
        end else if (scan_s) begin
            idx_r  <= idx_r + idx_t'(1);
        end
    end

    for (genvar g = 0; g < NUM_XCORRS; g++) begin : g_lane
        argmax_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .start    (capture_s),
            .en       (scan_s),
            .sample   (snap_r[g][idx_r]),
            .idx      (idx_r),
            .best     (best_s[g]),
            .best_idx (best_idx_s[g])
        );
    end

    // Registered outputs; results hold until the next DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r      <= 1'b0;
            valid_out_r <= 1'b0;
            lag_r       <= '0;
            peak_r      <= '0;
        end else begin
            busy_r      <= (next_state_s != ST_IDLE);
            valid_out_r <= done_s;
            if (done_s) begin
                for (int i = 0; i < NUM_XCORRS; i++) begin
                    lag_r[i]  <= idx_to_lag(best_idx_s[i]);
                    peak_r[i] <= best_s[i];
                end
            end
        end
    end

    // Saturating count of requests ignored while busy
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_r <= 8'd0;
        end else if (bus.validIn && (state_r != ST_IDLE) && (drop_r != 8'hFF)) begin
            drop_r <= drop_r + 8'd1;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.validOut  = valid_out_r;
    assign bus.lagOut    = lag_r;
    assign bus.peakOut   = peak_r;
    assign bus.dropCount = drop_r;

endmodule
